// File: rtl/sdram_pkg.sv
// sdram_pkg: encodings, widths and client state shared by the SDRAM controller and its clients
package sdram_pkg;
    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [2:0] WORK_IDLE    = 3'd0;
    localparam logic [2:0] WORK_READ    = 3'd1;
    localparam logic [2:0] WORK_WRITE   = 3'd2;
    localparam logic [2:0] WORK_REFRESH = 3'd3;
    localparam logic [2:0] WORK_INIT    = 3'd4;
    typedef enum logic [2:0] {IDLE, WAIT_NB, REQ, XFER, FINISH} client_state_t;
    function automatic logic [2:0] next_idx(input logic [3:0] b);
        return (b >= 4'(BURST_LEN - 1)) ? 3'(BURST_LEN - 1) : 3'(b + 4'd1);
    endfunction
endpackage

// File: rtl/sdram_burst_client_if.sv
// sdram_burst_client_if: request/ack user port between a burst client and the SDRAM controller
interface sdram_burst_client_if;
    import sdram_pkg::*;
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic              busy;
    logic              wr_ack;
    logic              rd_ack;
    logic              wr_done;
    logic              rd_done;
    logic [DATA_W-1:0] data_read;
    modport master(output wr_req, rd_req, addr, data_write,
                   input busy, wr_ack, rd_ack, wr_done, rd_done, data_read);
    modport slave(input wr_req, rd_req, addr, data_write,
                  output busy, wr_ack, rd_ack, wr_done, rd_done, data_read);
endinterface

// File: rtl/sdram_wbuf.sv
// sdram_wbuf: burst-sized write buffer, one sync write port and one async read port
module sdram_wbuf
    import sdram_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [2:0]        widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        ridx,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [BURST_LEN];
    // host load port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end
    assign rdata = mem[ridx];
endmodule

// File: rtl/sdram_burst_client.sv
// sdram_burst_client: issues one 8-word write or read burst per host command on the controller user port
module sdram_burst_client
    import sdram_pkg::*;
#(
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              wbuf_we,
    input  logic [2:0]        wbuf_idx,
    input  logic [DATA_W-1:0] wbuf_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_word,
    output logic [2:0]        rd_idx,
    output logic              op_done,
    output logic              op_err,
    sdram_burst_client_if.master bus
);
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [3:0] BL = 4'(BURST_LEN);
    client_state_t     state;
    logic              op_wr;
    logic              ovr;
    logic [3:0]        beat;
    logic [TW-1:0]     tmo;
    logic              ack;
    logic              done;
    logic              take;
    logic              over;
    logic [3:0]        beat_n;
    logic [2:0]        ridx;
    logic [DATA_W-1:0] wq;
    assign cmd_ready = state == IDLE;
    assign ack       = op_wr ? bus.wr_ack : bus.rd_ack;
    assign done      = op_wr ? bus.wr_done : bus.rd_done;
    assign take      = state != IDLE && state != WAIT_NB && ack && beat != BL;
    assign over      = state != IDLE && state != WAIT_NB && ack && beat == BL;
    assign beat_n    = beat + 4'(take);
    assign ridx      = take ? next_idx(beat) : 3'd0;
    sdram_wbuf u_wbuf (
        .clk  (clk),
        .we   (wbuf_we && cmd_ready),
        .widx (wbuf_idx),
        .wdata(wbuf_data),
        .ridx (ridx),
        .rdata(wq)
    );
    // burst sequencer: request, beat counting, data staging and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_wr          <= 1'b0;
            ovr            <= 1'b0;
            beat           <= '0;
            tmo            <= '0;
            bus.wr_req     <= 1'b0;
            bus.rd_req     <= 1'b0;
            bus.addr       <= '0;
            bus.data_write <= '0;
            rd_valid       <= 1'b0;
            rd_word        <= '0;
            rd_idx         <= '0;
            op_done        <= 1'b0;
            op_err         <= 1'b0;
        end else begin
            rd_valid <= take && !op_wr;
            op_done  <= 1'b0;
            op_err   <= over && !ovr;
            beat     <= beat_n;
            if (over) ovr <= 1'b1;
            if (take) begin
                rd_word <= bus.data_read;
                rd_idx  <= beat[2:0];
            end
            if (op_wr && (take || state == WAIT_NB)) bus.data_write <= wq;
            case (state)
                IDLE: if (cmd_valid) begin
                    bus.addr <= cmd_addr;
                    op_wr    <= cmd_wr;
                    beat     <= '0;
                    tmo      <= '0;
                    ovr      <= 1'b0;
                    state    <= WAIT_NB;
                end
                WAIT_NB: if (!bus.busy) begin
                    bus.wr_req <= op_wr;
                    bus.rd_req <= !op_wr;
                    state      <= REQ;
                end
                REQ: if (ack) begin
                    bus.wr_req <= 1'b0;
                    bus.rd_req <= 1'b0;
                    state      <= XFER;
                end else if (tmo == TW'(TMO_CYC - 1)) begin
                    bus.wr_req <= 1'b0;
                    bus.rd_req <= 1'b0;
                    op_err     <= 1'b1;
                    state      <= IDLE;
                end else begin
                    tmo <= tmo + TW'(1);
                end
                XFER, FINISH: if (done) begin
                    op_done <= beat_n == BL;
                    op_err  <= beat_n != BL || (over && !ovr);
                    state   <= IDLE;
                end else if (state == XFER && beat == BL && !ack) begin
                    state <= FINISH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_burst_client.sv
// tb_sdram_burst_client: scoreboard bench with a scripted controller model
module tb_sdram_burst_client;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [21:0] cmd_addr = '0;
    logic        wbuf_we = 1'b0;
    logic [2:0]  wbuf_idx = '0;
    logic [15:0] wbuf_data = '0;
    logic        rd_valid;
    logic [15:0] rd_word;
    logic [2:0]  rd_idx;
    logic        op_done;
    logic        op_err;
    sdram_burst_client_if bus();
    sdram_burst_client dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .wbuf_we(wbuf_we), .wbuf_idx(wbuf_idx),
        .wbuf_data(wbuf_data), .rd_valid(rd_valid), .rd_word(rd_word), .rd_idx(rd_idx),
        .op_done(op_done), .op_err(op_err), .bus(bus)
    );
    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [15:0] word;
    } rexp_t;
    rexp_t       rq[$];
    logic [15:0] wb_model [8];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mon_beat = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rv_cnt = 0;
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // monitor: write data on ack cycles, read words against the scoreboard, pulse counts
    always @(negedge clk) begin
        if (rst) begin
            mon_beat = 0;
            rq.delete();
        end else begin
            if (cmd_valid && cmd_ready) mon_beat = 0;
            if (bus.wr_req || bus.rd_req) check("req_excl", 32'(bus.wr_req & bus.rd_req), 0);
            if (bus.wr_ack) begin
                if (mon_beat < 8) check("wdata", 32'(bus.data_write), 32'(wb_model[mon_beat]));
                mon_beat++;
            end
            if (bus.rd_ack) begin
                if (mon_beat < 8) rq.push_back('{cyc + 1, 3'(mon_beat), bus.data_read});
                mon_beat++;
            end
            if (rd_valid) begin
                rv_cnt++;
                if (rq.size() == 0) begin
                    check("rd_spurious", 32'(rd_valid), 0);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    check("rd_word", 32'(rd_word), 32'(e.word));
                    check("rd_idx", 32'(rd_idx), 32'(e.idx));
                    check("rd_lat", 32'(cyc), 32'(e.cyc));
                end
            end
            if (op_done) done_cnt++;
            if (op_err) err_cnt++;
        end
    end
    task automatic load(input logic [2:0] i, input logic [15:0] d);
        wbuf_we = 1'b1;
        wbuf_idx = i;
        wbuf_data = d;
        if (cmd_ready) wb_model[i] = d;
        tick();
        wbuf_we = 1'b0;
    endtask
    task automatic issue(input bit wr, input logic [21:0] a, input bit ld, input logic [15:0] ld_d);
        cmd_wr = wr;
        cmd_addr = a;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        if (ld) begin
            wbuf_we = 1'b1;
            wbuf_idx = 3'd0;
            wbuf_data = ld_d;
            wb_model[0] = ld_d;
        end
        tick();
        cmd_valid = 1'b0;
        wbuf_we = 1'b0;
        check("cmd_taken", 32'(cmd_ready), 0);
        check("addr_latch", 32'(bus.addr), 32'(a));
    endtask
    task automatic wait_req(input bit wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = wr ? bus.wr_req : bus.rd_req;
        end
        check("req_seen", 32'(ok), 1);
    endtask
    task automatic burst(input bit wr, input int n_ack, input int done_dly);
        bit ok;
        wait_req(wr, ok);
        if (ok) begin
            tick();
            for (int i = 0; i < n_ack; i++) begin
                if (wr) bus.wr_ack = 1'b1; else bus.rd_ack = 1'b1;
                bus.data_read = 16'h00A0 + 16'(i);
                tick();
                if (i == 0) check("req_drop", 32'(wr ? bus.wr_req : bus.rd_req), 0);
            end
            bus.wr_ack = 1'b0;
            bus.rd_ack = 1'b0;
            repeat (done_dly) tick();
            if (wr) bus.wr_done = 1'b1; else bus.rd_done = 1'b1;
            tick();
            bus.wr_done = 1'b0;
            bus.rd_done = 1'b0;
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int d0, e0, v0, n;
        bit ok;
        bus.busy = 1'b0;
        bus.wr_ack = 1'b0;
        bus.rd_ack = 1'b0;
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        bus.data_read = '0;
        repeat (3) tick();
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_wr_req", 32'(bus.wr_req), 0);
        check("rst_rd_req", 32'(bus.rd_req), 0);
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_wdata", 32'(bus.data_write), 0);
        check("rst_pulses", {29'd0, rd_valid, op_done, op_err}, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) load(3'(i), 16'h1000 + 16'(i));
        d0 = done_cnt; e0 = err_cnt;
        issue(1'b1, 22'h12345, 1'b0, 16'h0);
        burst(1'b1, 8, 2);
        repeat (2) tick();
        check("wr_done_cnt", 32'(done_cnt - d0), 1);
        check("wr_err_cnt", 32'(err_cnt - e0), 0);
        d0 = done_cnt; e0 = err_cnt; v0 = rv_cnt;
        issue(1'b0, 22'h3FF00, 1'b0, 16'h0);
        burst(1'b0, 8, 2);
        repeat (2) tick();
        check("rd_done_cnt", 32'(done_cnt - d0), 1);
        check("rd_err_cnt", 32'(err_cnt - e0), 0);
        check("rd_valid_cnt", 32'(rv_cnt - v0), 8);
        check("rd_q_empty", 32'(rq.size()), 0);
        d0 = done_cnt; e0 = err_cnt;
        bus.busy = 1'b1;
        issue(1'b1, 22'h00ABC, 1'b0, 16'h0);
        load(3'd1, 16'hDEAD);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.wr_req || bus.rd_req) n++;
            tick();
        end
        check("busy_noreq", 32'(n), 0);
        bus.busy = 1'b0;
        tick();
        check("busy_req", 32'(bus.wr_req), 1);
        burst(1'b1, 8, 1);
        repeat (2) tick();
        check("busy_done_cnt", 32'(done_cnt - d0), 1);
        check("busy_err_cnt", 32'(err_cnt - e0), 0);
        e0 = err_cnt; d0 = done_cnt;
        issue(1'b0, 22'h01000, 1'b0, 16'h0);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.rd_req) n++;
            tick();
        end
        check("tmo_len", 32'(n), 255);
        check("tmo_err_cnt", 32'(err_cnt - e0), 1);
        check("tmo_done_cnt", 32'(done_cnt - d0), 0);
        check("tmo_ready", 32'(cmd_ready), 1);
        d0 = done_cnt; e0 = err_cnt;
        issue(1'b1, 22'h0F0F0, 1'b0, 16'h0);
        burst(1'b1, 9, 2);
        repeat (2) tick();
        check("ovr_err_cnt", 32'(err_cnt - e0), 1);
        check("ovr_done_cnt", 32'(done_cnt - d0), 1);
        d0 = done_cnt; e0 = err_cnt;
        issue(1'b0, 22'h0A5A5, 1'b0, 16'h0);
        burst(1'b0, 6, 2);
        repeat (2) tick();
        check("short_err_cnt", 32'(err_cnt - e0), 1);
        check("short_done_cnt", 32'(done_cnt - d0), 0);
        d0 = done_cnt; e0 = err_cnt;
        issue(1'b1, 22'h2AAAA, 1'b0, 16'h0);
        wait_req(1'b1, ok);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.wr_ack = 1'b1;
            tick();
        end
        bus.wr_ack = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_mid_wr_req", 32'(bus.wr_req), 0);
        check("rst_mid_ready", 32'(cmd_ready), 1);
        check("rst_mid_pulses", {30'd0, op_done, op_err}, 0);
        rst = 1'b0;
        repeat (2) tick();
        check("rst_mid_cnt", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
        issue(1'b1, 22'h15555, 1'b1, 16'hBEEF);
        burst(1'b1, 8, 1);
        repeat (2) tick();
        check("post_rst_done", 32'(done_cnt - d0), 1);
        check("post_rst_err", 32'(err_cnt - e0), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sdram_burst_client.md
Name: sdram_burst_client

Overview:
- Bus-side master for the SDRAM controller's request/ack user port. It drives wr_req, rd_req, addr and data_write, and consumes busy, wr_ack, rd_ack, wr_done, rd_done and data_read.
- It holds one 8-word write buffer, loaded by the host, and streams it out on wr_ack cycles.
- It captures 8 read words on rd_ack cycles and presents them to the host as a valid stream.
- It sits between host logic (UART/test pattern generator) and the SDRAM controller, at 125 MHz in the controller's clock domain.

Parameters:
- ADDR_W, 22, controller address width ({bank[1:0], row[11:0], col[7:0]}).
- DATA_W, 16, data width.
- BURST_LEN, 8, words per burst; must match the mode register burst length.
- TMO_CYC, 255, cycles allowed from request to first ack before timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  host command strobe.
- cmd_ready  out  1  client idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  burst start address.
- wbuf_we  in  1  write-buffer load strobe.
- wbuf_idx  in  3  write-buffer word index.
- wbuf_data  in  DATA_W  write-buffer word.
- rd_valid  out  1  read word valid (one cycle per word).
- rd_word  out  DATA_W  read word.
- rd_idx  out  3  index of the read word within the burst.
- op_done  out  1  one-cycle pulse when a burst completes normally.
- op_err  out  1  one-cycle pulse on timeout or ack overrun.
- wr_req  out  1  to controller.
- rd_req  out  1  to controller.
- addr  out  ADDR_W  to controller.
- data_write  out  DATA_W  to controller.
- busy  in  1  from controller.
- wr_ack  in  1  from controller.
- rd_ack  in  1  from controller.
- wr_done  in  1  from controller.
- rd_done  in  1  from controller.
- data_read  in  DATA_W  from controller.

Behaviour:
- Reset values: state IDLE; wr_req, rd_req, rd_valid, op_done and op_err all 0; addr 0; data_write 0; cmd_ready 1. Write-buffer contents are not reset.
- Reset asserted mid-operation: both requests drop on the next edge and the burst is abandoned. There is no done or err pulse.
- States: IDLE, WAIT_NB, REQ, XFER, FINISH.
- IDLE:
  - cmd_ready = 1.
  - On command acceptance: latch cmd_addr into addr and cmd_wr into op_wr, then go to WAIT_NB.
- WAIT_NB:
  - Wait for busy == 0, then go to REQ.
  - No timeout in this state, because the controller may be in init or refresh.
- REQ:
  - Assert wr_req (if op_wr) or rd_req (if not op_wr).
  - The timeout counter increments each cycle.
  - On the first wr_ack/rd_ack: drop the request on the next edge and go to XFER. The ack cycle itself is counted as beat 0.
  - If TMO_CYC cycles elapse without an ack: drop the request, pulse op_err, go to IDLE.
- Address and data ordering:
  - addr is held constant from acceptance until the state returns to IDLE.
  - Write: data_write = wbuf[0] from entry to REQ through the first wr_ack cycle.
  - Write: after each wr_ack cycle, data_write advances to wbuf[beat+1]. The index saturates at BURST_LEN-1.
  - Read: in each rd_ack cycle, register data_read to rd_word with rd_idx = beat, and pulse rd_valid the next cycle. Latency is 1 cycle, in order.
- Beat counter:
  - Width is 4 bits and it counts acks.
  - An ack after BURST_LEN beats is an overrun: pulse op_err once and ignore the data. The burst still finishes on done.
- XFER → FINISH: when beat == BURST_LEN and the ack is low.
- FINISH:
  - Wait for wr_done (write) or rd_done (read).
  - Pulse op_done, then go to IDLE.
  - A done arriving during XFER is also accepted; the state goes straight to IDLE with op_done.
- A done seen with fewer than BURST_LEN beats gives op_err instead of op_done.
- Write buffer:
  - wbuf_we is honoured only when cmd_ready = 1; otherwise it is ignored.
  - A load and a command acceptance in the same cycle: the load is applied first, so the burst uses the new word.
- cmd_valid while not ready is ignored; the host must hold it.
- wr_req and rd_req are never asserted together.

Decomposition:
- Shared package sdram_pkg holds:
  - CMD_* and WORK_* encodings shared with the controller;
  - ADDR_W, DATA_W and BURST_LEN;
  - client state typedef.
- One sub-module, sdram_wbuf: an 8×DATA_W register file with one write port and one async read port, indexed by beat.

Test Plan:
- Write burst: load wbuf 0x1000..0x1007, cmd_wr = 1, addr 0x12345, controller model acks 8 cycles → data_write shows 0x1000..0x1007, one per ack. wr_req deasserts 1 cycle after the first ack. op_done pulses once after wr_done.
- Read burst: cmd_wr = 0, addr 0x3FF00, model returns 0xA0..0xA7 on rd_ack → rd_valid ×8 with rd_idx 0..7 and words 0xA0..0xA7, each 1 cycle after its ack, then op_done.
- Busy gating: controller busy high for 300 cycles (refresh/init) → no request and no op_err. The request is issued 1 cycle after busy falls.
- Timeout: model never acks → after 255 cycles the request drops, op_err pulses, cmd_ready returns to 1.
- Overrun/short burst: 9 acks → op_err once, then op_done. A second run with 6 acks then done → op_err, no op_done.
- Reset in XFER after beat 3 → wr_req = 0, cmd_ready = 1 next cycle, no pulses. A new write then completes normally.
